regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of write-back results and of the register-file write port, SHALL be provided.
REQ-002 Parameter REGW, default 5, register index width, SHALL be provided.
REQ-003 Parameter DEPTH, default 2, per-requester queue depth (power of two, >=2), SHALL be provided.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req0_valid  input  1  requester 0 (ALU write-back) offers a result.
REQ-007 req0_ready  output  1  requester 0 entry accepted this edge when valid&ready.
REQ-008 req0_rd  input  REGW  destination register index, requester 0.
REQ-009 req0_data  input  XLEN  result value, requester 0.
REQ-010 req1_valid, req1_ready, req1_rd, req1_data SHALL mirror REQ-006..009 for requester 1 (load/long-latency write-back).
REQ-011 reg_write  output  1  register-file write enable.
REQ-012 write_reg  output  REGW  register-file write index.
REQ-013 write_data  output  XLEN  register-file write data.
REQ-014 wb_idle  output  1  high when both queues are empty.

Function
REQ-015 Each requester SHALL own a DEPTH-entry FIFO of {rd, data}; reqN_ready SHALL equal "FIFO N not full", registered-state only, with no combinational path from any input.
REQ-016 A handshake (valid&ready at an edge) SHALL push one entry; valid without ready SHALL leave inputs to be held by the requester.
REQ-017 Each cycle at most one FIFO head SHALL be granted and popped at the next edge; reg_write/write_reg/write_data SHALL be driven combinationally from the granted head.
REQ-018 Latency: an entry accepted at edge N into an empty FIFO with no competing head SHALL appear on the write port during cycle N+1.
REQ-019 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the preferred requester when both heads are valid; after any grant to requester i the pointer SHALL point to the other requester.
REQ-020 With a single non-empty FIFO, that FIFO SHALL be granted regardless of the pointer, and the pointer SHALL still update per REQ-019.
REQ-021 A granted entry with rd==0 SHALL be popped but reg_write SHALL be 0 that cycle.
REQ-022 When no head is valid, reg_write SHALL be 0 and write_reg/write_data SHALL be 0.
REQ-023 Simultaneous push and pop on the same FIFO SHALL keep its occupancy unchanged; a full FIFO SHALL not accept a push even if popped in the same cycle.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL use a count of width log2(DEPTH)+1.
REQ-025 Per-requester order SHALL be preserved; ordering between requesters to the same rd is the requesters' responsibility.

Reset
REQ-026 rst SHALL asynchronously empty both FIFOs, set the pointer to prefer requester 0, and force reg_write=0, write_reg=0, write_data=0, req0_ready=req1_ready=1, wb_idle=1.
REQ-027 Entries held in the FIFOs when rst asserts mid-operation SHALL be discarded and never written.

Structure
REQ-028 XLEN/REGW defaults and the {rd, data} entry typedef SHALL reside in the shared core package.
REQ-029 The FIFO SHALL be one sub-module, wb_fifo, instantiated twice; arbitration SHALL live in the top module.

Verification
REQ-030 Reset, req0 pushes rd=5,data=0xDEADBEEF at edge 1 -> cycle 2: reg_write=1, write_reg=5, write_data=0xDEADBEEF; cycle 3: wb_idle=1.
REQ-031 Both push at edge 1 (rd=3/0x11, rd=4/0x22) -> cycle 2 writes rd=3, cycle 3 writes rd=4 (pointer starts at req0).
REQ-032 Both held valid continuously with 6 entries each -> grants alternate 0,1,0,1...; no requester granted twice in a row while the other is non-empty.
REQ-033 req1 pushes 3 entries back-to-back while req0 monopolises grants (DEPTH=2) -> req1_ready=0 after 2 pushes until its first pop; no entry lost or duplicated.
REQ-034 req0 pushes rd=0,data=0x55 -> entry popped in cycle 2 with reg_write=0; following entry rd=7 written in cycle 3.
REQ-035 rst asserted mid-cycle with 2 queued entries -> outputs zero immediately, no write of the queued entries after reset release, ready=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core package for the register-file write-back arbiter.
//   XLEN_DEF / REGW_DEF : default data and register-index widths
//   wb_entry_t          : one queued write-back, {rd, data}
//   prio_e              : round-robin priority pointer encoding
//   rr_next()           : pointer value after a grant
package regfile_wb_arbiter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  typedef struct packed {
    logic [REGW_DEF-1:0] rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_e;

  // After serving one requester the other one becomes preferred.
  function automatic prio_e rr_next(input logic granted_req1);
    return granted_req1 ? PRIO_REQ0 : PRIO_REQ1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus bundle: two requester channels plus the register-file
// write port and the idle flag.
//   master modport : requester side (drives valid/rd/data, sees the rest)
//   slave modport  : arbiter side
// Handshake: a requester entry transfers on a rising edge where both
// reqN_valid and reqN_ready are high. reqN_ready depends only on registered
// queue state. While valid is high without ready, the requester holds
// rd/data stable. The write port has no back-pressure.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            req0_valid;
  logic            req0_ready;
  logic [REGW-1:0] req0_rd;
  logic [XLEN-1:0] req0_data;
  logic            req1_valid;
  logic            req1_ready;
  logic [REGW-1:0] req1_rd;
  logic [XLEN-1:0] req1_data;
  logic            reg_write;
  logic [REGW-1:0] write_reg;
  logic [XLEN-1:0] write_data;
  logic            wb_idle;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  reg_write, write_reg, write_data, wb_idle
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output reg_write, write_reg, write_data, wb_idle
  );
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: small synchronous FIFO holding packed {rd, data} write-back
// entries for one requester.
//   clk, rst : clock, asynchronous active-high reset (empties the queue)
//   i_push   : push request; ignored while full (even if popped that edge)
//   i_din    : entry to push
//   i_pop    : pop request; ignored while empty
//   o_dout   : head entry (valid when !o_empty)
//   o_empty  : no entries held
//   o_full   : DEPTH entries held
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_dout  = r_mem[r_rptr];

  // Fullness is judged on registered state only, so a pop on the same edge
  // never frees room for a push.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // DEPTH is a power of two, so plain AW-bit increments wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges two write-back streams (ALU on requester 0,
// loads / long-latency units on requester 1) onto one register-file write
// port. Each requester has its own queue; one queue head is granted per
// cycle with round-robin priority and popped at the next edge.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave modport carrying both requester channels, the
//              reg_write/write_reg/write_data port and wb_idle
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int REGW  = REGW_DEF,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int EW = REGW + XLEN;

  logic [EW-1:0] w_head0;
  logic [EW-1:0] w_head1;
  logic          w_empty0;
  logic          w_empty1;
  logic          w_full0;
  logic          w_full1;
  logic          w_pop0;
  logic          w_pop1;
  logic          w_any;
  logic          w_gnt1;
  logic [EW-1:0] w_gnt_entry;
  prio_e         r_prio;

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.req0_valid),
    .i_din   ({bus.req0_rd, bus.req0_data}),
    .i_pop   (w_pop0),
    .o_dout  (w_head0),
    .o_empty (w_empty0),
    .o_full  (w_full0)
  );

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.req1_valid),
    .i_din   ({bus.req1_rd, bus.req1_data}),
    .i_pop   (w_pop1),
    .o_dout  (w_head1),
    .o_empty (w_empty1),
    .o_full  (w_full1)
  );

  assign bus.req0_ready = ~w_full0;
  assign bus.req1_ready = ~w_full1;
  assign bus.wb_idle    = w_empty0 & w_empty1;

  // Requester 1 wins when it is the only non-empty queue, or when both
  // are non-empty and the pointer prefers it.
  always_comb begin
    w_any       = ~w_empty0 | ~w_empty1;
    w_gnt1      = ~w_empty1 & (w_empty0 | (r_prio == PRIO_REQ1));
    w_pop0      = w_any & ~w_gnt1;
    w_pop1      = w_gnt1;
    w_gnt_entry = '0;
    if (w_gnt1)         w_gnt_entry = w_head1;
    else if (!w_empty0) w_gnt_entry = w_head0;
  end

  // x0 is hard-wired zero: the entry is still consumed, only the write
  // enable is suppressed.
  assign bus.write_reg  = w_gnt_entry[EW-1 -: REGW];
  assign bus.write_data = w_gnt_entry[XLEN-1:0];
  assign bus.reg_write  = w_any & (w_gnt_entry[EW-1 -: REGW] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= PRIO_REQ0;
    end else if (w_any) begin
      r_prio <= rr_next(w_gnt1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int EW   = $bits(wb_entry_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .REGW(REGW), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int            n_total = 0;
  int            n_bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic          rdy1_hist [0:63];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_rd    = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_rd    = '0;
    bus.req1_data  = '0;
  endtask

  // Leaves the bench 1 time unit after an edge with rst just released;
  // the next rising edge is "edge 1".
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [EW-1:0] entry(input int i, input int k);
    wb_entry_t e;
    e.rd   = REGW'(i * 8 + k + 1);
    e.data = 32'hA000_0000 | 32'(i << 8) | 32'(k);
    return e;
  endfunction

  // Both requesters stream n0/n1 entries, honouring ready. Every write seen
  // on the port is checked against exp_q in order.
  task automatic run_stream(input int n0, input int n1, input string tag);
    int i0;
    int i1;
    bit done;
    logic s0;
    logic s1;
    i0 = 0;
    i1 = 0;
    done = 1'b0;
    bus.req0_valid = (n0 > 0);
    {bus.req0_rd, bus.req0_data} = entry(0, 0);
    bus.req1_valid = (n1 > 0);
    {bus.req1_rd, bus.req1_data} = entry(1, 0);
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      s0 = bus.req0_valid & bus.req0_ready;
      s1 = bus.req1_valid & bus.req1_ready;
      step();
      if (s0) begin
        i0++;
        bus.req0_valid = (i0 < n0);
        {bus.req0_rd, bus.req0_data} = entry(0, i0);
      end
      if (s1) begin
        i1++;
        bus.req1_valid = (i1 < n1);
        {bus.req1_rd, bus.req1_data} = entry(1, i1);
      end
      rdy1_hist[cyc + 1] = bus.req1_ready;
      if (bus.reg_write) begin
        if (exp_q.size() == 0)
          chk({tag, " unexpected write"}, 64'(bus.reg_write), 64'(0));
        else
          chk({tag, " write"}, 64'({bus.write_reg, bus.write_data}), 64'(exp_q.pop_front()));
      end
      if (i0 == n0 && i1 == n1 && bus.wb_idle) done = 1'b1;
    end
    chk({tag, " finished"}, 64'(done), 64'(1));
    chk({tag, " leftover"}, 64'(exp_q.size()), 64'(0));
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) rdy1_hist[i] = 1'bx;

    // Reset state, then a single write from requester 0.
    idle_inputs();
    rst = 1'b1;
    step();
    chk("rst reg_write", 64'(bus.reg_write), 64'(0));
    chk("rst write_reg", 64'(bus.write_reg), 64'(0));
    chk("rst write_data", 64'(bus.write_data), 64'(0));
    chk("rst ready0", 64'(bus.req0_ready), 64'(1));
    chk("rst ready1", 64'(bus.req1_ready), 64'(1));
    chk("rst idle", 64'(bus.wb_idle), 64'(1));
    step();
    rst = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_rd    = 5'd5;
    bus.req0_data  = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    chk("single reg_write", 64'(bus.reg_write), 64'(1));
    chk("single write_reg", 64'(bus.write_reg), 64'(5));
    chk("single write_data", 64'(bus.write_data), 64'hDEAD_BEEF);
    chk("single idle busy", 64'(bus.wb_idle), 64'(0));
    step();
    chk("single idle", 64'(bus.wb_idle), 64'(1));
    chk("empty reg_write", 64'(bus.reg_write), 64'(0));
    chk("empty write_reg", 64'(bus.write_reg), 64'(0));
    chk("empty write_data", 64'(bus.write_data), 64'(0));

    // Simultaneous pushes: requester 0 first after reset.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 32'h11;
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd4; bus.req1_data = 32'h22;
    step();
    idle_inputs();
    chk("both c2 reg_write", 64'(bus.reg_write), 64'(1));
    chk("both c2 write_reg", 64'(bus.write_reg), 64'(3));
    chk("both c2 write_data", 64'(bus.write_data), 64'h11);
    step();
    chk("both c3 reg_write", 64'(bus.reg_write), 64'(1));
    chk("both c3 write_reg", 64'(bus.write_reg), 64'(4));
    chk("both c3 write_data", 64'(bus.write_data), 64'h22);
    step();
    chk("both c4 idle", 64'(bus.wb_idle), 64'(1));

    // Continuous contention: grants strictly alternate 0,1,0,1...
    do_reset();
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(entry(0, k));
      exp_q.push_back(entry(1, k));
    end
    run_stream(6, 6, "alt");

    // Requester 1 fills its queue and is back-pressured until its first pop.
    do_reset();
    exp_q.push_back(entry(0, 0));
    exp_q.push_back(entry(1, 0));
    exp_q.push_back(entry(0, 1));
    exp_q.push_back(entry(1, 1));
    exp_q.push_back(entry(1, 2));
    run_stream(2, 3, "bp");
    chk("bp ready1 c2", 64'(rdy1_hist[2]), 64'(1));
    chk("bp ready1 c3 full", 64'(rdy1_hist[3]), 64'(0));
    chk("bp ready1 c4", 64'(rdy1_hist[4]), 64'(1));

    // rd==0 is consumed without a write; the next entry follows.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd0; bus.req0_data = 32'h55;
    step();
    bus.req0_rd = 5'd7; bus.req0_data = 32'h77;
    chk("x0 c2 reg_write", 64'(bus.reg_write), 64'(0));
    chk("x0 c2 idle", 64'(bus.wb_idle), 64'(0));
    step();
    idle_inputs();
    chk("x0 c3 reg_write", 64'(bus.reg_write), 64'(1));
    chk("x0 c3 write_reg", 64'(bus.write_reg), 64'(7));
    chk("x0 c3 write_data", 64'(bus.write_data), 64'h77);
    step();
    chk("x0 c4 idle", 64'(bus.wb_idle), 64'(1));

    // Mid-cycle reset discards queued entries.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd9;  bus.req0_data = 32'h99;
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd10; bus.req1_data = 32'hAA;
    step();
    idle_inputs();
    chk("mrst pre reg_write", 64'(bus.reg_write), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mrst reg_write", 64'(bus.reg_write), 64'(0));
    chk("mrst write_reg", 64'(bus.write_reg), 64'(0));
    chk("mrst write_data", 64'(bus.write_data), 64'(0));
    chk("mrst ready0", 64'(bus.req0_ready), 64'(1));
    chk("mrst ready1", 64'(bus.req1_ready), 64'(1));
    chk("mrst idle", 64'(bus.wb_idle), 64'(1));
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mrst after reg_write", 64'(bus.reg_write), 64'(0));
    end
    chk("mrst after idle", 64'(bus.wb_idle), 64'(1));

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
